bcd_conv_sched: RTL and testbench
=================================

Name: bcd_conv_sched

Overview:
- Shared sequential binary-to-BCD conversion engine for the accelerometer driver.
- Arbitrates round-robin among N_CH axis requesters (X/Y/Z by default) and captures the winner's sample.
- Converts the sample by iterative shift-add-3 (double dabble), one bit per cycle.
- Presents the BCD result, tagged with its channel, to the display path on a valid/ready handshake.

Parameters:
- W, 8, binary input width per channel; BCD result width is BW = W+(W-4)/3+1.
- N_CH, 3, number of requesting channels (2..8).
- CW, $clog2(N_CH), channel tag width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset (asserted at 0).
- enable  in  1  when 0, no new grants; an in-flight conversion still completes.
- req  in  N_CH  per-channel request; held high with data stable until ack.
- bin_in  in  N_CH*W  flattened samples, channel i at bits [i*W +: W].
- ack  out  N_CH  one-cycle one-hot pulse to the granted channel on capture.
- bcd_out  out  BW  BCD digits, least-significant digit at [3:0].
- ch_out  out  CW  channel tag of bcd_out.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  high from capture until the result handshake completes.

Behaviour:
- Reset (async assert, sync release) sets ack=0, bcd_out=0, ch_out=0, out_valid=0, busy=0, FSM=IDLE, RR pointer=0, shift/bit counters=0.
- FSM states are IDLE, CONV and DONE.
- IDLE, grant condition: enable=1 and |req.
  - Grant the first requesting channel at or after the RR pointer, wrapping modulo N_CH.
  - Latch bin_in for that channel into the shift register and clear the BCD accumulator.
  - Register the channel tag, set ack[g]=1 for the next cycle only, set busy=1, load bit counter=W, go to CONV.
  - Set RR pointer = (g+1) mod N_CH.
- IDLE with no grant condition: outputs hold; ack stays 0.
- CONV, each cycle:
  - In every 4-bit digit of the accumulator, add 3 if the digit is >=5.
  - Shift {accumulator, shift register} left by 1.
  - Decrement the counter.
  - When the counter reaches 1 on this cycle, the final shift is done: load bcd_out and ch_out, set out_valid=1, go to DONE.
- Latency: out_valid rises exactly W cycles after the cycle in which ack is high (ack in cycle k, valid from cycle k+W).
- DONE holds out_valid, bcd_out and ch_out stable until out_valid&&out_ready on a rising edge.
  - That edge clears out_valid and busy and returns the FSM to IDLE.
  - The earliest next ack is the cycle after the return to IDLE; back-to-back results need no idle gap beyond this.
- Result width: the top digit may be partial (e.g. 2 bits for W=8). Adjust/add-3 applies only to full 4-bit digits. Values never overflow BW.
- req dropped before ack: no capture, no error.
- req asserted in CONV/DONE is not sampled until IDLE.
- enable deasserted in CONV/DONE: the current result still completes and is delivered; the next grant waits for enable=1.
- Reset mid-operation aborts immediately with no valid pulse. Requesters still holding req are re-arbitrated from channel 0 after release.
- A single requester is granted repeatedly; the RR pointer has no effect with one active req.

Optional Feature:
- Macro: BCD_SIGN_EN.
- Defined:
  - bin_in lanes are two's complement.
  - At capture the magnitude is taken (negate if MSB=1), and the magnitude is converted.
  - Extra output sign_out (1 bit) is registered alongside bcd_out, reset 0, held in DONE.
  - Full negative range: -2^(W-1) converts to magnitude 2^(W-1).
- Undefined: inputs are unsigned and the sign_out port does not exist.

Test Plan:
- Single conversion: req[0]=1, bin_in ch0=255 -> ack[0] for one cycle; 8 cycles later out_valid=1, bcd_out=10'h255, ch_out=0. With out_ready=1, out_valid drops the next cycle.
- Zero and boundaries: ch1=0 -> bcd_out=10'h000; ch1=9 -> 10'h009; ch1=100 -> 10'h100. Each result appears 8 cycles after its ack.
- Round-robin: all req high, ch0=12, ch1=34, ch2=200, out_ready=1 -> results in order (ch0,10'h012), (ch1,10'h034), (ch2,10'h200), then ch0 again.
- Backpressure: out_ready=0 for 20 cycles after valid -> bcd_out/ch_out stable, busy=1, no ack. Raising out_ready completes the transfer and the next grant follows.
- Reset/enable:
  - reset=0 at cycle 4 of CONV -> all outputs 0 immediately, no out_valid afterward until a new request.
  - enable=0 during CONV -> that result is still delivered; no further ack until enable=1.
- BCD_SIGN_EN build: ch0=8'h80 (-128) -> sign_out=1, bcd_out=10'h128; ch0=8'h7F -> sign_out=0, bcd_out=10'h127.

Source files
------------

// File: rtl/bcd_conv_sched_if.sv
// Request/result bus of the shared binary-to-BCD engine.
// sign_out exists only when BCD_SIGN_EN is defined.
interface bcd_conv_sched_if #(
  parameter int unsigned W    = 8,
  parameter int unsigned N_CH = 3
);
  localparam int unsigned BW = W + (W - 4) / 3 + 1;
  localparam int unsigned CW = $clog2(N_CH);

  logic              enable;
  logic [N_CH-1:0]   req;
  logic [N_CH*W-1:0] bin_in;
  logic [N_CH-1:0]   ack;
  logic [BW-1:0]     bcd_out;
  logic [CW-1:0]     ch_out;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
`ifdef BCD_SIGN_EN
  logic              sign_out;
`endif

  modport master (
    output enable, req, bin_in, out_ready,
`ifdef BCD_SIGN_EN
    input  sign_out,
`endif
    input  ack, bcd_out, ch_out, out_valid, busy
  );

  modport slave (
    input  enable, req, bin_in, out_ready,
`ifdef BCD_SIGN_EN
    output sign_out,
`endif
    output ack, bcd_out, ch_out, out_valid, busy
  );
endinterface

// File: rtl/bcd_conv_sched.sv
// Round-robin shared double-dabble converter, one bit per cycle.
// Define BCD_SIGN_EN for two's-complement lanes with a registered sign_out.
module bcd_conv_sched #(
  parameter int unsigned W    = 8,
  parameter int unsigned N_CH = 3
) (
  input logic             clk,
  input logic             reset,
  bcd_conv_sched_if.slave bus
);
  localparam int unsigned BW   = W + (W - 4) / 3 + 1;
  localparam int unsigned CW   = $clog2(N_CH);
  localparam int unsigned NDIG = BW / 4;
  localparam int unsigned CNTW = $clog2(W + 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   tag_q, tag_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [BW-1:0]   acc_q, acc_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0] ack_q, ack_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
`ifdef BCD_SIGN_EN
  logic            sign_cap_q, sign_cap_d;
  logic            sign_q, sign_d;
`endif

  // Add 3 to every full digit >= 5; a partial top digit never needs it.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    r = a;
    for (int unsigned d = 0; d < NDIG; d++) begin
      if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Round-robin: first requester at or above the pointer, else the lowest one.
  logic          found_hi, found_lo, grant_found;
  logic [CW-1:0] idx_hi, idx_lo, grant_idx;

  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int unsigned j = 0; j < N_CH; j++) begin
      if (!found_hi && bus.req[j] && (CW'(j) >= rr_q)) begin
        found_hi = 1'b1;
        idx_hi   = CW'(j);
      end
      if (!found_lo && bus.req[j]) begin
        found_lo = 1'b1;
        idx_lo   = CW'(j);
      end
    end
    grant_found = found_hi | found_lo;
    grant_idx   = found_hi ? idx_hi : idx_lo;
  end

  logic [W-1:0] lane;
  logic [W-1:0] mag;
  logic         lane_neg;

  always_comb begin
    lane = bus.bin_in[grant_idx*W +: W];
`ifdef BCD_SIGN_EN
    lane_neg = lane[W-1];
    mag      = lane_neg ? (~lane + W'(1)) : lane;
`else
    lane_neg = 1'b0;
    mag      = lane;
`endif
  end

  logic [BW+W-1:0] pair_shl;
  assign pair_shl = {add3(acc_q), shift_q} << 1;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    tag_d   = tag_q;
    ch_d    = ch_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    valid_d = valid_q;
    busy_d  = busy_q;
`ifdef BCD_SIGN_EN
    sign_cap_d = sign_cap_q;
    sign_d     = sign_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.enable && grant_found) begin
          shift_d = mag;
          acc_d   = '0;
          tag_d   = grant_idx;
          ack_d   = N_CH'(1) << grant_idx;
          busy_d  = 1'b1;
          cnt_d   = CNTW'(W);
          rr_d    = (grant_idx == CW'(N_CH - 1)) ? '0 : grant_idx + CW'(1);
          state_d = StConv;
`ifdef BCD_SIGN_EN
          sign_cap_d = lane_neg;
`endif
        end
      end
      StConv: begin
        acc_d   = pair_shl[BW+W-1:W];
        shift_d = pair_shl[W-1:0];
        cnt_d   = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          bcd_d   = pair_shl[BW+W-1:W];
          ch_d    = tag_q;
          valid_d = 1'b1;
          state_d = StDone;
`ifdef BCD_SIGN_EN
          sign_d = sign_cap_q;
`endif
        end
      end
      StDone: begin
        if (valid_q && bus.out_ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      rr_q    <= '0;
      tag_q   <= '0;
      ch_q    <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef BCD_SIGN_EN
      sign_cap_q <= 1'b0;
      sign_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      tag_q   <= tag_d;
      ch_q    <= ch_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef BCD_SIGN_EN
      sign_cap_q <= sign_cap_d;
      sign_q     <= sign_d;
`endif
    end
  end

  assign bus.ack       = ack_q;
  assign bus.bcd_out   = bcd_q;
  assign bus.ch_out    = ch_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
`ifdef BCD_SIGN_EN
  assign bus.sign_out  = sign_q;
`endif

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed and random checks of bcd_conv_sched against a decimal-arithmetic model
// with a round-robin pick over the bench's own request vector.
module tb_bcd_conv_sched;
  localparam int unsigned W    = 8;
  localparam int unsigned N_CH = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_conv_sched_if #(.W(W), .N_CH(N_CH)) bus ();

  bcd_conv_sched #(.W(W), .N_CH(N_CH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int rr_m   = 0;
  logic [W-1:0]    lane [N_CH];
  logic [N_CH-1:0] req_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < N_CH; i++) bus.bin_in[i*W +: W] = lane[i];
    bus.req = req_v;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bcd_of(input int unsigned v);
    logic [31:0] r;
    int unsigned d;
    r = '0;
    d = 0;
    while (v > 0) begin
      r = r | (32'(v % 10) << (4 * d));
      v = v / 10;
      d++;
    end
    return r;
  endfunction

  function automatic int unsigned mag_of(input logic [W-1:0] x);
`ifdef BCD_SIGN_EN
    if (x[W-1]) return (32'd1 << W) - 32'(x);
`endif
    return 32'(x);
  endfunction

  function automatic logic sign_of(input logic [W-1:0] x);
`ifdef BCD_SIGN_EN
    return x[W-1];
`else
    return 1'b0;
`endif
  endfunction

  function automatic int pick(input logic [N_CH-1:0] r, input int ptr);
    for (int k = 0; k < N_CH; k++) begin
      if (r[(ptr + k) % N_CH]) return (ptr + k) % N_CH;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rand_val();
    int unsigned s;
    s = $urandom_range(3, 0);
    if (s == 0) return {W{1'b1}};
    if (s == 1) return '0;
    return W'($urandom);
  endfunction

  // One full transaction: grant, conversion latency, result, optional stall, handshake.
  task automatic run_one(input int bp, input bit reraise, input bit en_drop);
    int g;
    int n;
    logic [W-1:0] v;
    logic [31:0]  exp_b;
    bit stable;
    g = pick(req_v, rr_m);
    if (g < 0) g = 0;
    v = lane[g];
    exp_b = bcd_of(mag_of(v));
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.ack == '0 && n < 4);
    check("ack_latency", n, 1);
    check("ack_onehot", bus.ack, 32'd1 << g);
    check("busy_capture", bus.busy, 1);
    rr_m = (g + 1) % N_CH;
    req_v[g] = 1'b0;
    if (reraise) begin
      lane[g]  = W'($urandom);
      req_v[g] = 1'b1;
    end
    if (en_drop) begin
      bus.enable = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        if (!req_v[c]) lane[c] = W'($urandom);
      end
      req_v = '1;
    end
    drive();
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) check("ack_pulse", bus.ack, 0);
    end while (!bus.out_valid && n < W + 4);
    check("valid_latency", n, W);
    check("bcd_out", bus.bcd_out, exp_b);
    check("ch_out", bus.ch_out, g);
`ifdef BCD_SIGN_EN
    check("sign_out", bus.sign_out, sign_of(v));
`endif
    stable = 1'b1;
    for (int k = 0; k < bp; k++) begin
      tick();
      if (bus.bcd_out !== exp_b[9:0] || bus.ch_out !== 2'(g) || bus.out_valid !== 1'b1 ||
          bus.busy !== 1'b1 || bus.ack !== '0) stable = 1'b0;
    end
    if (bp > 0) check("backpressure_hold", stable, 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("valid_drop", bus.out_valid, 0);
    check("busy_drop", bus.busy, 0);
    if (en_drop) begin
      stable = 1'b1;
      for (int k = 0; k < 5; k++) begin
        tick();
        if (bus.ack !== '0 || bus.busy !== 1'b0) stable = 1'b0;
      end
      check("enable_off_no_ack", stable, 1);
      bus.enable = 1'b1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit quiet;
    reset         = 1'b0;
    bus.enable    = 1'b1;
    bus.out_ready = 1'b0;
    req_v         = '0;
    for (int i = 0; i < N_CH; i++) lane[i] = '0;
    drive();
    tick();
    tick();
    check("rst_ack", bus.ack, 0);
    check("rst_bcd", bus.bcd_out, 0);
    check("rst_ch", bus.ch_out, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
`ifdef BCD_SIGN_EN
    check("rst_sign", bus.sign_out, 0);
`endif
    reset = 1'b1;
    tick();
    tick();
    check("idle_no_req_ack", bus.ack, 0);

    // Single conversion of 255.
    lane[0] = 8'd255; req_v = 3'b001; drive();
    run_one(0, 1'b0, 1'b0);

    // Zero and digit boundaries on a single requester.
    lane[1] = 8'd0;   req_v = 3'b010; drive(); run_one(0, 1'b0, 1'b0);
    lane[1] = 8'd9;   req_v = 3'b010; drive(); run_one(0, 1'b0, 1'b0);
    lane[1] = 8'd100; req_v = 3'b010; drive(); run_one(0, 1'b0, 1'b0);

    // Round-robin with all requesters held high.
    lane[0] = 8'd12; lane[1] = 8'd34; lane[2] = 8'd200; req_v = 3'b111; drive();
    for (int k = 0; k < 4; k++) run_one(0, 1'b1, 1'b0);
    req_v = '0; drive();
    tick();
    check("req_dropped_no_ack", bus.ack, 0);

    // Backpressure for 20 cycles.
    lane[2] = 8'd187; req_v = 3'b100; drive();
    run_one(20, 1'b0, 1'b0);

    // Enable dropped during conversion; follow-up grant after re-enable.
    lane[0] = 8'd58; req_v = 3'b001; drive();
    run_one(0, 1'b0, 1'b1);
    run_one(0, 1'b0, 1'b0);
    req_v = '0; drive();
    tick();

    // Reset in the middle of a conversion.
    lane[1] = 8'd77; req_v = 3'b010; drive();
    tick();
    check("pre_reset_ack", bus.ack, 3'b010);
    req_v = '0; drive();
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b0;
    #1;
    check("midrst_ack", bus.ack, 0);
    check("midrst_bcd", bus.bcd_out, 0);
    check("midrst_ch", bus.ch_out, 0);
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    tick();
    tick();
    reset = 1'b1;
    rr_m  = 0;
    quiet = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    check("post_reset_quiet", quiet, 1);
    lane[0] = 8'd5; lane[1] = 8'd6; lane[2] = 8'd7; req_v = 3'b111; drive();
    run_one(0, 1'b0, 1'b0);
    req_v = '0; drive();

    // Extremes of the signed range (unsigned 128/127 in the default build).
    lane[0] = 8'h80; req_v = 3'b001; drive(); run_one(0, 1'b0, 1'b0);
    lane[0] = 8'h7F; req_v = 3'b001; drive(); run_one(0, 1'b0, 1'b0);

    // Random requests and values.
    for (int it = 0; it < 30; it++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (!req_v[c] && $urandom_range(1, 0) == 1) begin
          lane[c]  = rand_val();
          req_v[c] = 1'b1;
        end
      end
      if (req_v == '0) begin
        lane[0]  = rand_val();
        req_v[0] = 1'b1;
      end
      drive();
      run_one(int'($urandom_range(3, 0)), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
